hazard_stall_unit: RTL and testbench

//  Decode-stage hazard controller for the 5-stage MIPS pipeline with FP extension.

---
 rtl/hazard_stall_unit_pkg.sv | 25 ++
 rtl/hazard_stall_unit_fp_busy_counter.sv | 33 +++
 rtl/hazard_stall_unit.sv | 108 ++++++++++
 tb/tb_hazard_stall_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the decode-stage hazard logic: opcode constants,
// the hazard FSM state type, and a helper that classifies which opcodes
// read rt as a source operand.
package hazard_stall_unit_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_FP    = 6'd17;
  localparam logic [5:0] OPC_ADDI  = 6'd8;
  localparam logic [5:0] OPC_LW    = 6'd35;
  localparam logic [5:0] OPC_SW    = 6'd43;
  localparam logic [5:0] OPC_BEQ   = 6'd4;

  // Encoding kept identical to the control unit's HZ_IDLE / HZ_FP_BUSY.
  typedef enum logic [0:0] {
    HZ_IDLE    = 1'b0,
    HZ_FP_BUSY = 1'b1
  } hz_state_t;

  // Instructions whose rt field is a source register (not a destination).
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OPC_RTYPE) || (opcode == OPC_FP) ||
           (opcode == OPC_SW)    || (opcode == OPC_BEQ);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_fp_busy_counter.sv
// fp_busy_counter: loadable down-counter with a zero flag, used to time the
// remaining cycles of a non-pipelined FP adder occupancy.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (cnt -> 0)
//   load, load_val  load cnt with load_val (takes priority over dec)
//   dec             decrement cnt by one (caller guarantees cnt != 0)
//   cnt             current count
//   zero            1 when cnt == 0
module fp_busy_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: decode-stage hazard controller. Inserts a one-cycle
// bubble for load-use hazards and an FP_LAT-1 cycle stall while the
// non-pipelined FP adder occupies EX.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ifid_opcode/rs/rt   fields of the instruction in ID
//   idex_mem_read       instruction in EX is a load
//   idex_rt             load destination of the instruction in EX
//   idex_fp             instruction in EX is an FP add
//   control_mux_select  1 = bubble into ID/EX
//   pc_write            1 = PC may update
//   ifid_write          1 = IF/ID may load
//   fp_busy             1 while the FSM is in FP_BUSY
//   stall_cycles        saturating stall-cycle count (only with
//                       HAZARD_PERF_CNT_EN defined)
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned FP_LAT = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  ifid_opcode,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  input  logic        idex_fp,
  output logic        control_mux_select,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        fp_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  localparam int unsigned LOAD_INT = (FP_LAT > 2) ? (FP_LAT - 3) : 0;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_INT);
  localparam bit FP_MULTI = (FP_LAT > 2);

  hz_state_t        state, state_nxt;
  logic             load_hit;
  logic             stall;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt;

  assign load_hit = idex_mem_read && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) ||
                     (uses_rt(ifid_opcode) && (idex_rt == ifid_rt)));

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state)
      HZ_IDLE: begin
        stall = load_hit || idex_fp;
        if (idex_fp && FP_MULTI) begin
          state_nxt = HZ_FP_BUSY;
          cnt_load  = 1'b1;
        end
      end
      HZ_FP_BUSY: begin
        stall = 1'b1;
        if (cnt_zero) state_nxt = HZ_IDLE;
        else          cnt_dec   = 1'b1;
      end
      default: state_nxt = HZ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HZ_IDLE;
    else        state <= state_nxt;
  end

  fp_busy_counter #(.CNT_W(CNT_W)) u_fp_busy_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Outputs are forced to their reset values combinationally while rst_n
  // is low, so a mid-stream reset takes effect within the same cycle.
  assign control_mux_select = stall || !rst_n;
  assign pc_write           = !stall && rst_n;
  assign ifid_write         = !stall && rst_n;
  assign fp_busy            = (state == HZ_FP_BUSY) && rst_n;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  ifid_opcode = '0;
  logic [4:0]  ifid_rs = '0;
  logic [4:0]  ifid_rt = '0;
  logic        idex_mem_read = 1'b0;
  logic [4:0]  idex_rt = '0;
  logic        idex_fp = 1'b0;
  logic        control_mux_select, pc_write, ifid_write, fp_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int unsigned total = 0;
  int unsigned bad = 0;

  // Expected {control_mux_select, pc_write, ifid_write, fp_busy}
  localparam logic [3:0] N = 4'b0110;  // no stall
  localparam logic [3:0] S = 4'b1000;  // stall from IDLE
  localparam logic [3:0] B = 4'b1001;  // stall in FP_BUSY
  localparam logic [3:0] R = 4'b1000;  // reset values

  logic [3:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  hazard_stall_unit #(.FP_LAT(4), .CNT_W(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ifid_opcode        (ifid_opcode),
    .ifid_rs            (ifid_rs),
    .ifid_rt            (ifid_rt),
    .idex_mem_read      (idex_mem_read),
    .idex_rt            (idex_rt),
    .idex_fp            (idex_fp),
    .control_mux_select (control_mux_select),
    .pc_write           (pc_write),
    .ifid_write         (ifid_write),
    .fp_busy            (fp_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles       (stall_cycles)
`endif
  );

  // Drive one cycle of inputs just after the rising edge and queue the
  // response expected during that cycle.
  task automatic cyc(input logic rn, input logic [5:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic mr, input logic [4:0] xrt,
                     input logic fp, input logic [3:0] e, input string nm);
    @(posedge clk);
    #1;
    rst_n = rn; ifid_opcode = op; ifid_rs = rs; ifid_rt = rt;
    idex_mem_read = mr; idex_rt = xrt; idex_fp = fp;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input logic [3:0] e, input string nm);
    cyc(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, e, nm);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  initial begin
    logic [3:0] e, a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {control_mux_select, pc_write, ifid_write, fp_busy};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got cms/pcw/ifw/busy=%b expected %b", nm, a, e);
        end
      end
    end
  end

  initial begin
    // Reset state and release
    cyc(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, R, "reset_hold");
    idle(N, "reset_release");
    idle(N, "idle");
    // Mid-stream reset with a load hit present: reset values win
    cyc(1'b0, OPC_RTYPE, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, R, "midstream_reset");
    idle(N, "midstream_release");

    // Load-use hit on rs: exactly one stall cycle
    cyc(1'b1, OPC_RTYPE, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, S, "load_hit_rs");
    idle(N, "load_hit_after");
    // Negative: idex_rt == 0
    cyc(1'b1, OPC_RTYPE, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, N, "load_rt_zero");
    // Negative: ADDI does not read rt
    cyc(1'b1, OPC_ADDI, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, N, "load_addi_rt");
    // Positive: SW reads rt
    cyc(1'b1, OPC_SW, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, S, "load_sw_rt");
    // Negative: no mem_read
    cyc(1'b1, OPC_RTYPE, 5'd5, 5'd5, 1'b0, 5'd5, 1'b0, N, "no_mem_read");

    // FP stall: 3 cycles, fp_busy on cycles 2-3
    cyc(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, S, "fp_c1");
    idle(B, "fp_c2");
    idle(B, "fp_c3");
    idle(N, "fp_done");

    // Back-to-back FP ops
    cyc(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, S, "b2b_a1");
    idle(B, "b2b_a2");
    idle(B, "b2b_a3");
    cyc(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, S, "b2b_b1");
    idle(B, "b2b_b2");
    idle(B, "b2b_b3");
    idle(N, "b2b_done");

    // FP and load together: FP wins; inputs ignored in FP_BUSY
    cyc(1'b1, OPC_RTYPE, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, S, "fp_ld_c1");
    cyc(1'b1, OPC_RTYPE, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, B, "fp_ld_c2");
    cyc(1'b1, OPC_RTYPE, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, B, "fp_ld_c3");
    idle(N, "fp_ld_done");

    // Reset in 2nd FP_BUSY cycle
    cyc(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, S, "rst_fp_c1");
    idle(B, "rst_fp_c2");
    cyc(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, R, "rst_fp_reset");
    idle(N, "rst_fp_release");
    idle(N, "rst_fp_idle");

`ifdef HAZARD_PERF_CNT_EN
    cyc(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, R, "perf_reset");
    idle(N, "perf_release");
    cyc(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, S, "perf_fp1");
    idle(B, "perf_fp2");
    idle(B, "perf_fp3");
    cyc(1'b1, OPC_RTYPE, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, S, "perf_ld");
    idle(N, "perf_after");
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'd4) begin
      bad++;
      $display("FAIL perf_count4: got %0d expected 4", stall_cycles);
    end
    @(posedge clk);
    #1;
    idex_mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    for (int unsigned i = 0; i < 70000; i++) @(posedge clk);
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'hFFFF) begin
      bad++;
      $display("FAIL perf_saturate: got %h expected ffff", stall_cycles);
    end
    idle(N, "perf_end");
`endif

    // Let the monitor drain, bounded
    for (int unsigned i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
